// File: rtl/raw_bayer_demosaic_p.sv
// raw_bayer_demosaic_p: Bayer RAW to RGB via one line buffer and a 2x2 window.
// Define RAW_DEMOSAIC_WB_EN to add latched white-balance gains (+1 cycle).
module raw_bayer_demosaic_p #(
    parameter int DATA_W = 12,
    parameter int MAX_W  = 2048,
    parameter int Y_W    = 12
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_vs,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_pattern,
`ifdef RAW_DEMOSAIC_WB_EN
    input  logic [9:0]        i_gain_r,
    input  logic [9:0]        i_gain_g,
    input  logic [9:0]        i_gain_b,
`endif
    output logic [DATA_W-1:0] o_r,
    output logic [DATA_W-1:0] o_g,
    output logic [DATA_W-1:0] o_b,
    output logic              o_dval,
    output logic              o_ovf
);

    localparam int            XW   = $clog2(MAX_W);
    localparam logic [XW-1:0] XMAX = XW'(MAX_W - 1);

    logic          armed_q;
    logic [1:0]    pat_q;
    logic [XW-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic          req_q;
    logic          xmax_q;
    logic          ovf_q;
    logic          vreq;
    logic          at_max;
    logic          ovf_now;

    // Pixels only count once a frame start has been seen since reset.
    assign vreq    = i_req & i_vs & armed_q;
    assign at_max  = (x_q == XMAX);
    assign ovf_now = vreq & at_max & xmax_q;

    always_comb begin
        x_d = '0;
        if (vreq) begin
            x_d = at_max ? x_q : x_q + XW'(1);
        end
        y_d = y_q;
        if (req_q && !vreq) begin
            y_d = y_q + Y_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed_q <= 1'b0;
            pat_q   <= 2'b00;
            x_q     <= '0;
            y_q     <= '0;
            req_q   <= 1'b0;
            xmax_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (!i_vs) begin
            armed_q <= 1'b1;
            pat_q   <= i_pattern;
            x_q     <= '0;
            y_q     <= '0;
            req_q   <= 1'b0;
            xmax_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            req_q  <= vreq;
            xmax_q <= vreq & at_max;
            if (ovf_now) begin
                ovf_q <= 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] mem [MAX_W];
    logic [DATA_W-1:0] prv0_q;

    // Read-before-write: prv0_q gets the previous line's sample at x.
    always_ff @(posedge CLK) begin
        prv0_q <= mem[x_q];
        if (vreq && !ovf_now) begin
            mem[x_q] <= i_data;
        end
    end

    logic [DATA_W-1:0] cur0_q, cur1_q, prv1_q;
    logic              v1_q, z1_q, py1_q, px1_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur0_q <= '0;
            cur1_q <= '0;
            prv1_q <= '0;
            v1_q   <= 1'b0;
            z1_q   <= 1'b0;
            py1_q  <= 1'b0;
            px1_q  <= 1'b0;
        end else begin
            cur0_q <= i_data;
            cur1_q <= cur0_q;
            prv1_q <= prv0_q;
            v1_q   <= vreq;
            z1_q   <= ovf_now | (x_q == '0) | (y_q == '0);
            py1_q  <= y_q[0] ^ pat_q[1];
            px1_q  <= x_q[0] ^ pat_q[0];
        end
    end

    logic [DATA_W-1:0] r_s, b_s, ga_s, gb_s, g_s;
    logic [DATA_W:0]   gsum;

    // {py,px} is the phase of cur0; R sits at phase 00, B at 11.
    always_comb begin
        r_s  = '0;
        b_s  = '0;
        ga_s = '0;
        gb_s = '0;
        case ({py1_q, px1_q})
            2'b00: begin
                r_s = cur0_q; b_s = prv1_q;
                ga_s = cur1_q; gb_s = prv0_q;
            end
            2'b01: begin
                r_s = cur1_q; b_s = prv0_q;
                ga_s = cur0_q; gb_s = prv1_q;
            end
            2'b10: begin
                r_s = prv0_q; b_s = cur1_q;
                ga_s = cur0_q; gb_s = prv1_q;
            end
            default: begin
                r_s = prv1_q; b_s = cur0_q;
                ga_s = cur1_q; gb_s = prv0_q;
            end
        endcase
        gsum = {1'b0, ga_s} + {1'b0, gb_s};
        g_s  = gsum[DATA_W:1];
    end

    logic [DATA_W-1:0] r2_q, g2_q, b2_q;
    logic              v2_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r2_q <= '0;
            g2_q <= '0;
            b2_q <= '0;
            v2_q <= 1'b0;
        end else begin
            r2_q <= z1_q ? '0 : r_s;
            g2_q <= z1_q ? '0 : g_s;
            b2_q <= z1_q ? '0 : b_s;
            v2_q <= v1_q;
        end
    end

`ifdef RAW_DEMOSAIC_WB_EN
    function automatic logic [DATA_W-1:0] wb(
        input logic [DATA_W-1:0] s,
        input logic [9:0]        g
    );
        logic [DATA_W+9:0] p;
        p = {10'd0, s} * {{DATA_W{1'b0}}, g};
        return (|p[DATA_W+9:DATA_W+8]) ? '1 : p[DATA_W+7:8];
    endfunction

    logic [9:0]        gr_q, gg_q, gb_q;
    logic [DATA_W-1:0] r3_q, g3_q, b3_q;
    logic              v3_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gr_q <= 10'h100;
            gg_q <= 10'h100;
            gb_q <= 10'h100;
        end else if (!i_vs) begin
            gr_q <= i_gain_r;
            gg_q <= i_gain_g;
            gb_q <= i_gain_b;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r3_q <= '0;
            g3_q <= '0;
            b3_q <= '0;
            v3_q <= 1'b0;
        end else begin
            r3_q <= wb(r2_q, gr_q);
            g3_q <= wb(g2_q, gg_q);
            b3_q <= wb(b2_q, gb_q);
            v3_q <= v2_q;
        end
    end

    assign o_r    = r3_q;
    assign o_g    = g3_q;
    assign o_b    = b3_q;
    assign o_dval = v3_q;
`else
    assign o_r    = r2_q;
    assign o_g    = g2_q;
    assign o_b    = b2_q;
    assign o_dval = v2_q;
`endif

    assign o_ovf = ovf_q;

endmodule

// File: tb/tb_raw_bayer_demosaic_p.sv
// Scoreboard bench for raw_bayer_demosaic_p (DATA_W=12, MAX_W=8).
// Covers RAW_DEMOSAIC_WB_EN when that macro is defined.
module tb_raw_bayer_demosaic_p;

    localparam int DW = 12;
`ifdef RAW_DEMOSAIC_WB_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          i_vs = 1'b1;
    logic          i_req = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [1:0]    i_pattern = 2'b00;
    logic [9:0]    i_gain_r = 10'h100;
    logic [9:0]    i_gain_g = 10'h100;
    logic [9:0]    i_gain_b = 10'h100;
    logic [DW-1:0] o_r, o_g, o_b;
    logic          o_dval, o_ovf;

    raw_bayer_demosaic_p #(.DATA_W(DW), .MAX_W(8), .Y_W(12)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .i_vs(i_vs),
        .i_req(i_req),
        .i_data(i_data),
        .i_pattern(i_pattern),
`ifdef RAW_DEMOSAIC_WB_EN
        .i_gain_r(i_gain_r),
        .i_gain_g(i_gain_g),
        .i_gain_b(i_gain_b),
`endif
        .o_r(o_r),
        .o_g(o_g),
        .o_b(o_b),
        .o_dval(o_dval),
        .o_ovf(o_ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int r;
        int g;
        int b;
        int cyc;
        int tag;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   tag = 0;
    int   dval_cnt = 0;
    bit   mon_en = 1'b1;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST_N && o_dval) dval_cnt++;
        if (RST_N && mon_en && o_dval) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_dval cyc=%0d got r=%0d g=%0d b=%0d want no output",
                         cyc, o_r, o_g, o_b);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (int'(o_r) != e.r || int'(o_g) != e.g ||
                    int'(o_b) != e.b || (cyc - e.cyc) != LAT) begin
                    n_fail++;
                    $display("FAIL pix%0d got r=%0d g=%0d b=%0d lat=%0d want r=%0d g=%0d b=%0d lat=%0d",
                             e.tag, o_r, o_g, o_b, cyc - e.cyc, e.r, e.g, e.b, LAT);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic frame_start(input logic [1:0] p);
        i_req = 1'b0;
        i_vs = 1'b0;
        i_pattern = p;
        tick();
        tick();
        i_vs = 1'b1;
        tick();
    endtask

    task automatic px(input int d, input int er, input int eg, input int eb);
        exp_t e;
        i_req = 1'b1;
        i_data = DW'(d);
        e.r = er; e.g = eg; e.b = eb; e.cyc = cyc; e.tag = tag;
        sbq.push_back(e);
        tag++;
        tick();
    endtask

    task automatic zpx(input int d);
        px(d, 0, 0, 0);
    endtask

    task automatic rpx(input int d);
        i_req = 1'b1;
        i_data = DW'(d);
        tick();
    endtask

    task automatic gap(input int n);
        i_req = 1'b0;
        repeat (n) tick();
    endtask

    int l1r[8] = '{0, 1, 3, 3, 5, 5, 7, 7};
    int l1g[8] = '{0, 6, 7, 8, 9, 10, 11, 12};
    int l1b[8] = '{0, 12, 12, 14, 14, 16, 16, 18};
    int l2r[8] = '{0, 21, 23, 23, 25, 25, 27, 27};
    int l2g[8] = '{0, 16, 17, 18, 19, 20, 21, 22};
    int l2b[8] = '{0, 12, 12, 14, 14, 16, 16, 18};

    initial begin
        repeat (3) tick();
        chk("rst_r", 32'(o_r), 0);
        chk("rst_g", 32'(o_g), 0);
        chk("rst_b", 32'(o_b), 0);
        chk("rst_dval", 32'(o_dval), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // RGGB
        frame_start(2'b00);
        zpx(100); zpx(200); zpx(100); zpx(200);
        gap(3);
        zpx(300); px(400, 100, 250, 400); px(300, 100, 250, 400); px(400, 100, 250, 400);
        gap(3);

        // BGGR, then a mid-frame pattern change that must be ignored
        frame_start(2'b11);
        zpx(100); zpx(200); zpx(100); zpx(200);
        gap(3);
        zpx(300); px(400, 400, 250, 100); px(300, 400, 250, 100); px(400, 400, 250, 100);
        gap(3);
        i_pattern = 2'b00;
        zpx(500); px(600, 400, 450, 500); px(500, 400, 450, 500); px(600, 400, 450, 500);
        gap(3);
        frame_start(2'b00);
        zpx(100); zpx(200); zpx(100); zpx(200);
        gap(3);
        zpx(300); px(400, 100, 250, 400); px(300, 100, 250, 400); px(400, 100, 250, 400);
        gap(3);

        // green sum at full scale, and truncating average
        frame_start(2'b00);
        zpx(10); zpx(4095); zpx(7);
        gap(3);
        zpx(4095); px(20, 10, 4095, 20); px(4094, 7, 4094, 20);
        gap(3);

        // line overflow on MAX_W=8
        frame_start(2'b00);
        for (int i = 0; i < 8; i++) zpx(i + 1);
        gap(3);
        chk("ovf_line0", 32'(o_ovf), 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i >= 8) zpx(11 + i);
            else px(11 + i, l1r[i], l1g[i], l1b[i]);
        end
        gap(3);
        chk("ovf_set", 32'(o_ovf), 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) zpx(21 + i);
            else px(21 + i, l2r[i], l2g[i], l2b[i]);
        end
        gap(3);
        chk("ovf_sticky", 32'(o_ovf), 1);
        frame_start(2'b00);
        chk("ovf_clear", 32'(o_ovf), 0);

        // asynchronous reset in the middle of a line
        mon_en = 1'b0;
        frame_start(2'b00);
        rpx(100); rpx(200); rpx(100); rpx(200);
        gap(3);
        rpx(300); rpx(400); rpx(300);
        chk("pre_rst_dval", 32'(o_dval), 1);
        chk("pre_rst_r", 32'(o_r), 100);
        RST_N = 1'b0;
        #1;
        chk("midrst_dval", 32'(o_dval), 0);
        chk("midrst_r", 32'(o_r), 0);
        chk("midrst_g", 32'(o_g), 0);
        chk("midrst_b", 32'(o_b), 0);
        i_req = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        mon_en = 1'b1;
        dval_cnt = 0;
        rpx(300); rpx(400); rpx(300); rpx(400);
        gap(5);
        chk("no_dval_before_vs", 32'(dval_cnt), 0);

`ifdef RAW_DEMOSAIC_WB_EN
        // red gain 2.0 with saturation
        i_gain_r = 10'h200;
        frame_start(2'b00);
        zpx(3000); zpx(0); zpx(1000); zpx(0);
        gap(3);
        zpx(0); px(50, 4095, 0, 50); px(0, 2000, 0, 50); px(60, 2000, 0, 60);
        gap(4);
        i_gain_r = 10'h100;
`endif

        gap(6);
        chk("drain", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/raw_bayer_demosaic_p.md
Name: raw_bayer_demosaic_p

Overview:
Parametrised successor to the current fixed 12-bit Bayer-to-RGB path. It holds one line buffer and a 2x2 window, and generates its own pixel and line counters from the read-request stream. Unlike the current path, the Bayer phase is selectable at run time, line overflow is detected, and edge pixels are defined. It sits between the D8M frame-buffer read side and the VGA RGB output.

Parameters:
DATA_W, 12, raw and RGB sample width in bits.
MAX_W, 2048, maximum pixels per line; sets line-buffer depth and the x-counter width, clog2(MAX_W).
Y_W, 12, line-counter width.

Ports:
CLK  in  1  pixel clock; all logic on its rising edge.
RST_N  in  1  asynchronous, active-low reset.
i_vs  in  1  frame sync, active-low, sampled synchronously.
i_req  in  1  pixel-valid / read request; high for the active part of each line.
i_data  in  DATA_W  raw Bayer sample, valid when i_req=1.
i_pattern  in  2  Bayer phase: 00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR.
o_r  out  DATA_W  red.
o_g  out  DATA_W  green.
o_b  out  DATA_W  blue.
o_dval  out  1  output valid.
o_ovf  out  1  sticky line-overflow flag.

Behaviour:
- Reset: o_r, o_g, o_b = 0; o_dval = 0; o_ovf = 0; counters = 0; latched pattern = 00. Line-buffer contents are not reset.
- Frame start: on any cycle with i_vs=0, synchronously clear x, clear y, clear o_ovf, and latch i_pattern into pat_q.
  - pat_q is held for the whole frame. Changes to i_pattern while i_vs=1 are ignored.
  - Pixels presented while i_vs=0 are discarded; o_dval = 0.
- x counter: 0 while i_req=0. On each i_req=1 cycle, x increments after use. It saturates at MAX_W-1.
- Overflow: an i_req=1 cycle with x already at MAX_W-1 and the previous cycle also at MAX_W-1 sets o_ovf.
  - That pixel is not written to the buffer, and its output is forced to 0 (o_dval still 1).
- y counter: increments on the falling edge of i_req (previous i_req=1, current i_req=0). It wraps modulo 2^Y_W.
- Line buffer: single RAM, depth MAX_W.
  - At address x, read the old value (previous line) and write i_data in the same cycle.
  - Read-before-write semantics are required.
- Window, registered with the stage-1 register: cur0 = i_data at x, cur1 = i_data at x-1, prv0 = prev line at x, prv1 = prev line at x-1.
- Phase of the bottom-right sample: py = y[0]^pat_q[1], px = x[0]^pat_q[0].
  - cur0 has phase (py,px); cur1 has (py,~px); prv0 has (~py,px); prv1 has (~py,~px).
  - Phase (0,0) is R, phase (1,1) is B, and the other two are G.
- Arithmetic:
  - o_r = R sample; o_b = B sample.
  - o_g = (G_a + G_b) >> 1, summed in DATA_W+1 bits with truncating shift, so there is no overflow.
- Edges: for x==0 or y==0, o_r, o_g, o_b = 0 and o_dval = 1. Line timing is preserved.
- Latency: fixed at 2 cycles from i_req/i_data to o_*/o_dval (RAM read stage, then compute/output register).
  - o_dval is i_req delayed 2 cycles, gated by i_vs as above.
- Reset mid-line: all outputs return to reset values immediately. The next valid output appears only after the next i_vs low pulse.

Optional Feature:
RAW_DEMOSAIC_WB_EN
- Defined:
  - Adds input ports i_gain_r, i_gain_g, i_gain_b, each 10 bits, unsigned 2.8 format (0x100 = 1.0).
  - Gains are latched at frame start, like pat_q.
  - Each channel is multiplied by its gain, then shifted right by 8. Results above 2^DATA_W-1 saturate to all ones.
  - Adds one pipeline stage: latency becomes 3 and o_dval is delayed to match.
  - Reset value of the latched gains is 0x100.
- Not defined: the gain ports are absent, there is no multiplier, and latency is 2.

Test Plan:
1. DATA_W=12, MAX_W=8, pattern 00 (RGGB).
   - Stimulus: line 0 = 100,200,100,200; line 1 = 300,400,300,400.
   - Required: line 1, x=1 → R=100, G=(200+300)>>1=250, B=400.
   - Required: x=0 and all of line 0 → 0, with o_dval high.
   - Required: each output appears exactly 2 cycles after its input.
2. Same data with pattern 11 (BGGR): line 1, x=1 → R=400, G=250, B=100.
   - Then change i_pattern mid-frame: output is unchanged until after the next i_vs low.
3. Max-value G pair 4095 + 4095 → o_g = 4095, with no wrap.
4. MAX_W=8, 10-pixel line → o_ovf=1 from pixel 9 onward, pixels 9 and 10 output 0, buffer contents at address 7 intact; next i_vs low clears o_ovf.
5. Assert RST_N low mid-line → outputs 0 and o_dval=0 in the same cycle; after release, no o_dval until the following frame start.
6. With RAW_DEMOSAIC_WB_EN and i_gain_r=0x200:
   - R=3000 → o_r = 4095 (saturated).
   - R=1000 → o_r = 2000.
   - Latency is 3 cycles.
